// File: rtl/sort_7_frame_gather_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_7_frame_gather_if
// Description : Bundle of the input word stream and the framed parallel output
//               of sort_7_frame_gather.
//               master : drives the word stream and frame_ready (producer and
//                        consumer side)
//               slave  : the framing block itself
// Signals     : in_data/in_valid/in_last/in_ready  - input word stream
//               data_0..data_6                     - frame words, slot order
//               frame_valid/frame_ready            - frame handshake
//               frame_count                        - real words in frame (1..7)
//               frame_total                        - delivered frames, mod 2^16
// Revision    : 1.0 - initial release
// ============================================================================
interface sort_7_frame_gather_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] data_0;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic [31:0] data_3;
    logic [31:0] data_4;
    logic [31:0] data_5;
    logic [31:0] data_6;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  frame_count;
    logic [15:0] frame_total;

    modport master (
        output in_data, in_valid, in_last, frame_ready,
        input  in_ready, data_0, data_1, data_2, data_3, data_4, data_5, data_6,
               frame_valid, frame_count, frame_total
    );

    modport slave (
        input  in_data, in_valid, in_last, frame_ready,
        output in_ready, data_0, data_1, data_2, data_3, data_4, data_5, data_6,
               frame_valid, frame_count, frame_total
    );
endinterface
`default_nettype wire

// File: rtl/sort_7_frame_gather.sv
`default_nettype none
// ============================================================================
// Module      : sort_7_frame_gather
// Description : Packs a valid/ready stream of 32-bit words into 7-word frames,
//               pads short frames (in_last) with PAD and presents each frame as
//               seven registered parallel words with a valid/ready handshake.
//               A fill bank and an output bank allow one frame every 7 cycles.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - sort_7_frame_gather_if.slave (stream in, frame out)
// Parameters  : PAD  - fill value for unused slots of a short frame
// Revision    : 1.0 - initial release
// ============================================================================
module sort_7_frame_gather #(
    parameter logic [31:0] PAD = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    sort_7_frame_gather_if.slave  bus
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] fill_q [7];
    logic [31:0] data_q [7];
    logic [31:0] data_d [7];
    logic        frame_valid_q, frame_valid_d;
    logic [2:0]  frame_count_q, frame_count_d;
    logic [15:0] frame_total_q, frame_total_d;

    logic w_in_ready;
    logic w_accept;
    logic w_complete;
    logic w_out_free;
    logic w_load;

    always_comb begin
        w_in_ready = !rst && (state_q == S_FILL);
        w_accept   = bus.in_valid && w_in_ready;
        w_complete = w_accept && ((cnt_q == 3'd6) || bus.in_last);
        w_out_free = !frame_valid_q || bus.frame_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        w_load  = 1'b0;

        case (state_q)
            S_FILL: begin
                if (w_complete) begin
                    if (w_out_free) begin
                        w_load = 1'b1;
                        cnt_d  = 3'd0;
                    end else begin
                        // cnt_q is kept: it still indexes the last real word
                        state_d = S_FULL;
                    end
                end else if (w_accept) begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_FULL: begin
                if (w_out_free) begin
                    w_load  = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        frame_valid_d = frame_valid_q;
        frame_count_d = frame_count_q;
        for (int i = 0; i < 7; i++) begin
            data_d[i] = data_q[i];
        end

        if (w_load) begin
            frame_valid_d = 1'b1;
            frame_count_d = cnt_q + 3'd1;
            for (int i = 0; i < 7; i++) begin
                if (3'(i) < cnt_q) begin
                    data_d[i] = fill_q[i];
                end else if (3'(i) == cnt_q) begin
                    // In FILL the completing word has not reached the fill bank yet
                    data_d[i] = (state_q == S_FILL) ? bus.in_data : fill_q[i];
                end else begin
                    data_d[i] = PAD;
                end
            end
        end else if (bus.frame_ready) begin
            frame_valid_d = 1'b0;
        end

        frame_total_d = frame_total_q;
        if (frame_valid_q && bus.frame_ready) begin
            frame_total_d = frame_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FILL;
            cnt_q         <= 3'd0;
            frame_valid_q <= 1'b0;
            frame_count_q <= 3'd0;
            frame_total_q <= 16'd0;
            for (int i = 0; i < 7; i++) begin
                data_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            frame_total_q <= frame_total_d;
            for (int i = 0; i < 7; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Fill bank needs no reset: slots beyond the write index are never output
    always_ff @(posedge clk) begin
        if (w_accept) begin
            fill_q[cnt_q] <= bus.in_data;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.frame_total = frame_total_q;
    assign bus.data_0      = data_q[0];
    assign bus.data_1      = data_q[1];
    assign bus.data_2      = data_q[2];
    assign bus.data_3      = data_q[3];
    assign bus.data_4      = data_q[4];
    assign bus.data_5      = data_q[5];
    assign bus.data_6      = data_q[6];

endmodule
`default_nettype wire

// File: tb/tb_sort_7_frame_gather.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_7_frame_gather
// Description : Self-checking bench for sort_7_frame_gather. A queue-based
//               frame model tracks the partial frame, at most one waiting
//               frame and the presented frame; DUT outputs are compared every
//               cycle, plus directed checks for the notable scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_7_frame_gather;

    localparam logic [31:0] c_PAD = 32'hFFFF_FFFF;

    logic clk;
    logic rst;
    sort_7_frame_gather_if bus ();

    sort_7_frame_gather #(.PAD(c_PAD)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] cur [$];
    logic [31:0] m_data [7];
    logic [2:0]  m_count;
    logic        m_valid;
    logic [15:0] m_total;
    logic        m_pend;
    logic [31:0] m_pend_data [7];
    logic [2:0]  m_pend_count;
    bit          m_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_data(input int i);
        case (i)
            0: return bus.data_0;
            1: return bus.data_1;
            2: return bus.data_2;
            3: return bus.data_3;
            4: return bus.data_4;
            5: return bus.data_5;
            default: return bus.data_6;
        endcase
    endfunction

    // One clock cycle: check in_ready, advance model with the sampled inputs,
    // then compare all registered outputs.
    task automatic step();
        logic        v, l, fr, r;
        logic [31:0] d;
        logic        rdy, consume, free, loaded;
        logic [31:0] f [7];
        #1;
        v = bus.in_valid; l = bus.in_last; fr = bus.frame_ready; r = rst; d = bus.in_data;
        rdy = !r && !m_pend;
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        @(posedge clk);
        #1;
        m_acc = 1'b0;
        if (r) begin
            cur.delete();
            m_pend  = 1'b0;
            m_valid = 1'b0;
            m_count = 3'd0;
            m_total = 16'd0;
            for (int i = 0; i < 7; i++) m_data[i] = 32'd0;
        end else begin
            consume = m_valid && fr;
            free    = !m_valid || fr;
            loaded  = 1'b0;
            if (m_pend) begin
                if (free) begin
                    m_data  = m_pend_data;
                    m_count = m_pend_count;
                    m_pend  = 1'b0;
                    loaded  = 1'b1;
                end
            end else if (v) begin
                m_acc = 1'b1;
                cur.push_back(d);
                if (cur.size() == 7 || l) begin
                    for (int i = 0; i < 7; i++) f[i] = (i < cur.size()) ? cur[i] : c_PAD;
                    if (free) begin
                        m_data  = f;
                        m_count = 3'(cur.size());
                        loaded  = 1'b1;
                    end else begin
                        m_pend_data  = f;
                        m_pend_count = 3'(cur.size());
                        m_pend       = 1'b1;
                    end
                    cur.delete();
                end
            end
            if (loaded) m_valid = 1'b1;
            else if (consume) m_valid = 1'b0;
            if (consume) m_total = m_total + 16'd1;
        end
        check("frame_valid", 32'(bus.frame_valid), 32'(m_valid));
        check("frame_total", 32'(bus.frame_total), 32'(m_total));
        check("frame_count", 32'(bus.frame_count), 32'(m_count));
        for (int i = 0; i < 7; i++) check($sformatf("data_%0d", i), dut_data(i), m_data[i]);
    endtask

    task automatic send(input logic [31:0] w, input logic last);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        bus.in_last  = last;
        do begin
            step();
            n++;
        end while (!m_acc && n < 50);
        check("send_timeout", 32'(m_acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        bit          saw_low;
        logic [15:0] t0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = 32'd0; bus.frame_ready = 1'b0;
        m_acc = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_count = 3'd0; m_total = 16'd0;
        for (int i = 0; i < 7; i++) m_data[i] = 32'd0;

        // Reset state
        idle(2);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        idle(1);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_data_3", bus.data_3, 32'd0);

        // Full frames, no stall
        bus.frame_ready = 1'b1;
        saw_low = 1'b0;
        for (int w = 1; w <= 14; w++) begin
            if (!bus.in_ready) saw_low = 1'b1;
            send(32'(w), 1'b0);
            if (w == 7) check("full_f1_d6", bus.data_6, 32'd7);
        end
        check("full_f2_d0", bus.data_0, 32'd8);
        check("full_cnt", 32'(bus.frame_count), 32'd7);
        check("full_ready_low", 32'(saw_low), 32'd0);
        idle(1);
        check("full_total", 32'(bus.frame_total), 32'd2);

        // Short frame
        send(32'd5, 1'b0); send(32'd3, 1'b0); send(32'd9, 1'b1);
        check("short_d0", bus.data_0, 32'd5);
        check("short_d2", bus.data_2, 32'd9);
        check("short_d3", bus.data_3, c_PAD);
        check("short_cnt", 32'(bus.frame_count), 32'd3);
        idle(2);

        // Back-pressure
        bus.frame_ready = 1'b0;
        for (int w = 1; w <= 14; w++) send(32'(w), 1'b0);
        idle(3);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold_d0", bus.data_0, 32'd1);
        t0 = bus.frame_total;
        bus.frame_ready = 1'b1;
        step();
        bus.frame_ready = 1'b0;
        check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        check("bp_f2_d0", bus.data_0, 32'd8);
        check("bp_total", 32'(bus.frame_total), 32'(t0 + 16'd1));
        bus.frame_ready = 1'b1;
        idle(2);

        // Single-word frame and in_last on slot 6
        send(32'h42, 1'b1);
        check("single_cnt", 32'(bus.frame_count), 32'd1);
        check("single_d1", bus.data_1, c_PAD);
        for (int w = 0; w < 7; w++) send(32'(w + 20), (w == 6));
        check("last6_cnt", 32'(bus.frame_count), 32'd7);
        check("last6_d6", bus.data_6, 32'd26);
        idle(2);

        // Reset mid-operation
        bus.frame_ready = 1'b0;
        for (int w = 0; w < 11; w++) send(32'(w + 50), 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        check("mrst_valid", 32'(bus.frame_valid), 32'd0);
        check("mrst_d0", bus.data_0, 32'd0);
        check("mrst_total", 32'(bus.frame_total), 32'd0);
        bus.frame_ready = 1'b1;
        for (int w = 0; w < 7; w++) send(32'(w + 100), 1'b0);
        check("mrst_new_d0", bus.data_0, 32'd100);
        idle(2);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 199) == 0);
            bus.in_valid    = ($urandom_range(0, 9) < 7);
            bus.in_last     = ($urandom_range(0, 9) < 2);
            bus.in_data     = $urandom;
            bus.frame_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        rst = 1'b0;

        // Counter wrap: single-word frames every cycle
        do_reset();
        bus.frame_ready = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_last     = 1'b1;
        for (int c = 0; c < 65536; c++) begin
            bus.in_data = $urandom;
            step();
        end
        check("wrap_ffff", 32'(bus.frame_total), 32'h0000_FFFF);
        idle(1);
        check("wrap_zero", 32'(bus.frame_total), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sort_7_frame_gather.md
# sort_7_frame_gather

Upstream framing stage for the 7-input combinational sorter. Accepts a valid/ready stream of 32-bit words, packs them into 7-word frames, pads short frames, and presents each frame as seven parallel registered words with a valid/ready handshake. Its `data_0..data_6` outputs connect directly to the sorter's `data_0..data_6` inputs. Two register banks give one-frame-per-7-cycles sustained throughput.

## Interface
- `PAD`, default `32'hFFFF_FFFF`: fill value for unused slots of a short frame. Pads sort to the top indices.
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  32  stream word
- `in_valid`  in  1  `in_data` valid
- `in_last`  in  1  qualifies the current word as the final one of a frame (short-frame flush)
- `in_ready`  out  1  block can accept a word this cycle
- `data_0`..`data_6`  out  32 each  frame words, slot i = i-th accepted word of the frame
- `frame_valid`  out  1  output bank holds a frame
- `frame_ready`  in  1  consumer takes the frame
- `frame_count`  out  3  number of real (non-pad) words in the presented frame, 1..7
- `frame_total`  out  16  frames delivered (handshakes completed), wraps modulo 2^16

## Operation
- **Fill bank:** registers `f0..f6` plus write index `cnt` (0..6). Accept = `in_valid & in_ready` and writes `f[cnt]`.
- **Completion:** a frame completes on an accept with `cnt==6` or with `in_last==1`. `in_last` on the 7th word is the same as a full frame. `in_last` is ignored unless accepted.
- **Output bank is free** when `!frame_valid | frame_ready`.
- **FSM states:**
  - **FILL:** `in_ready=1`.
    - Accept without completion: `cnt++`.
    - Completion with output bank free: load the output bank on the same edge, `cnt←0`, stay FILL.
    - Completion with output bank not free: latch the word, go FULL.
  - **FULL:** `in_ready=0`. When the output bank is free: load the output bank, `cnt←0`, go FILL.
- **Output bank load:**
  - `data_i` = fill word i for `i < k`, where k is the number of real words; `data_i = PAD` for `i >= k`.
  - `frame_count ← k`; `frame_valid ← 1`.
  - The completing word is taken straight from `in_data` when loading in FILL.
- **Output handshake:**
  - `frame_valid & frame_ready` completes a transfer and increments `frame_total`.
  - If no load happens on the same edge, `frame_valid ← 0`.
  - While `frame_valid & !frame_ready`, `data_*` and `frame_count` hold stable.
- **Reset** (synchronous, `rst` high at an edge):
  - Clears: state FILL, `cnt=0`, `frame_valid=0`, `data_0..6=0`, `frame_count=0`, `frame_total=0`.
  - `in_ready=0` while `rst` is high.
  - A partial frame in the fill bank is discarded.
  - A frame in the output bank is dropped and is not counted.
- Stale fill-bank contents are never output; pad substitution is purely index-based.

## Timing
- `in_ready` is combinational from state and `rst` only. It does not depend on `in_valid` or `frame_ready` in the same cycle.
- **Latency:** the completing word is accepted at edge N; `frame_valid=1` with the full frame from edge N (visible in the cycle after N).
- **Sustained throughput:** with `frame_ready` held at 1, a new 7-word frame every 7 cycles, no bubbles on `in_ready`.
- **Back-pressure:**
  - At most one completed frame waits in FULL.
  - `in_ready` returns to 1 on the edge where the stalled frame moves to the output bank.
  - The earliest accept of the next frame's first word is the cycle after that edge.
- **Simultaneous consume and load** (`frame_valid & frame_ready` on a load edge): `frame_valid` stays 1, the new frame replaces the old one, and `frame_total` increments.
- `frame_total` wraps from 0xFFFF to 0x0000.

## Test plan
- **Full frames, no stall:** 14 words 1..14 with `in_valid` constant and `frame_ready=1` → `frame_valid` in the cycle after the 7th and after the 14th accept; frames (1..7) and (8..14); `frame_count=7`; `in_ready` never low; `frame_total=2`.
- **Short frame:** words 5, 3, 9 with `in_last` on 9 → `data_0..2` = 5, 3, 9; `data_3..6=32'hFFFF_FFFF`; `frame_count=3`. Feeding this to the sorter gives `sort_0..2` = 3, 5, 9.
- **Back-pressure:** `frame_ready=0`, stream 14 words → frame 1 presented and held stable; after the 14th accept `in_ready=0` (FULL). Raise `frame_ready` for one cycle → frame 2 loaded, `in_ready=1` the next cycle, `frame_total=1`.
- **Single-word frame and in_last on slot 6:** `in_last` on the first word → `frame_count=1`, `data_1..6=PAD`. `in_last` on the 7th word → identical to a full frame, `frame_count=7`.
- **Reset mid-operation:** assert `rst` after 4 accepts with a frame pending → next cycle `frame_valid=0`, all `data_*=0`, `frame_total=0`. The next 7 words form a frame starting at slot 0.
- **Counter wrap:** preload via 65 536 frames (or a forced value of 0xFFFF) → the next handshake yields `frame_total=0`.
